// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: serves word fetches from a preloadable RAM after
// a fixed wait-state latency, with a one-cycle ack and a fault flag.
module instr_mem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] FAULT_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     re,
    input  logic [XLEN/8-1:0]        sel,
    input  logic [XLEN-1:0]          addr,
    output logic                     ack,
    output logic [31:0]              instr,
    output logic                     fault,
    output logic                     busy,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            ack_q, ack_d;
    logic            fault_q, fault_d;
    logic [31:0]     instr_q;
    logic            rd_en;
    logic [XLEN-1:0] rd_addr;
    logic [AW-1:0]   widx;
    logic [31:0]     mem [DEPTH];

    // Fetches are always full-word, so the byte selects carry no information.
    logic sel_unused;
    assign sel_unused = ^sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        rd_en      = 1'b0;
        rd_addr    = req_addr_q;
        case (state_q)
            S_IDLE: begin
                if (re) begin
                    req_addr_d = addr;
                    cnt_d      = 4'(LATENCY - 1);
                    // With a single wait state the accept edge is also the read edge.
                    if (LATENCY == 1) begin
                        rd_en   = 1'b1;
                        rd_addr = addr;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!re) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rd_en   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ack_d   = rd_en;
        fault_d = (|rd_addr[1:0]) || (|rd_addr[XLEN-1:AW+2]);
        widx    = rd_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_addr_q <= '0;
            ack_q      <= 1'b0;
            fault_q    <= 1'b0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            ack_q      <= ack_d;
            if (rd_en) begin
                fault_q <= fault_d;
                instr_q <= fault_d ? FAULT_INSTR : mem[widx];
            end
        end
    end

    // Preload writes are independent of reset; a same-edge fetch sees old data.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign ack   = ack_q;
    assign instr = instr_q;
    assign fault = fault_q;
    assign busy  = (state_q != S_IDLE);

endmodule
